// File: rtl/bht_predictor_pkg.sv
// bp_pkg: default predictor geometry and the PC/history index hash.
package bp_pkg;
    localparam int N_DEF = 2;
    localparam int IDX_W_DEF = 4;
    localparam int HIST_W_DEF = 0;
    // Drops the byte offset, folds in history, then keeps the low idx_w bits.
    function automatic logic [31:0] bp_hash(input logic [31:0] pc, input logic [31:0] hist, input int idx_w);
        return ((pc >> 2) ^ hist) & ((32'd1 << idx_w) - 32'd1);
    endfunction
endpackage

// File: rtl/bht_predictor_sat_cell.sv
// sat_cell: next value of one saturating counter, and whether that value sits at either rail.
module sat_cell #(
    parameter int N = 2
) (
    input  logic [N-1:0] count,
    input  logic         inc,
    input  logic         en,
    output logic [N-1:0] next,
    output logic         sat
);
    localparam logic [N-1:0] MAX = '1;
    assign next = !en ? count : inc ? (count == MAX ? count : count + 1'b1) : (count == '0 ? count : count - 1'b1);
    assign sat = next == '0 || next == MAX;
endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: flop-based table of saturating counters, bimodal or gshare indexed,
// with 1-cycle registered lookup, write-first forwarding and a saturating miss counter.
module bht_predictor
    import bp_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int INIT = 2**(N-1)-1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        prediction,
    output logic        pred_strong,
    input  logic        branch,
    input  logic [31:0] upd_pc,
    input  logic        taken,
    output logic [15:0] miss_count
);
    localparam int ENTRIES = 2**IDX_W;
    localparam int GW = HIST_W > 0 ? HIST_W : 1;
    logic [N-1:0] cnt [ENTRIES];
    logic [N-1:0] nxt [ENTRIES];
    logic [ENTRIES-1:0] sat;
    logic [GW-1:0] ghr;
    logic [31:0] hist;
    logic [IDX_W-1:0] p_idx;
    logic [IDX_W-1:0] u_idx;
    logic miss;

    assign hist = HIST_W > 0 ? 32'(ghr) : 32'd0;
    assign p_idx = IDX_W'(bp_hash(pred_pc, hist, IDX_W));
    assign u_idx = IDX_W'(bp_hash(upd_pc, hist, IDX_W));
    assign miss = branch && (cnt[u_idx][N-1] != taken);

    // Lookups read each cell's next value, which gives write-first forwarding for free.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_cell
        sat_cell #(.N(N)) u_cell (
            .count(cnt[i]),
            .inc  (taken),
            .en   (branch && u_idx == IDX_W'(i)),
            .next (nxt[i]),
            .sat  (sat[i])
        );
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) cnt[i] <= N'(INIT);
            else cnt[i] <= nxt[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
            pred_valid <= 1'b0;
            prediction <= 1'b0;
            pred_strong <= 1'b0;
            miss_count <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                prediction <= nxt[p_idx][N-1];
                pred_strong <= sat[p_idx];
            end
            if (branch && HIST_W > 0) ghr <= GW'({ghr, taken});
            if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: bimodal, gshare and 1-bit instances checked against a behavioural table model.
module tb_bht_predictor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pred_req = 1'b0;
    logic branch = 1'b0;
    logic taken = 1'b0;
    logic [31:0] pred_pc = '0;
    logic [31:0] upd_pc = '0;
    logic [2:0] pv, pr, ps;
    logic [15:0] mc [3];
    int passed = 0;
    int total = 0;
    int m_cnt [2][16];
    int m_ghr [2];
    int m_miss [2];
    int m_pv [2];
    int m_pr [2];
    int m_ps [2];

    always #5 clk = ~clk;

    bht_predictor #(.N(2), .IDX_W(4), .HIST_W(0), .INIT(1)) u_bim (
        .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv[0]), .prediction(pr[0]), .pred_strong(ps[0]),
        .branch(branch), .upd_pc(upd_pc), .taken(taken), .miss_count(mc[0])
    );
    bht_predictor #(.N(2), .IDX_W(4), .HIST_W(2), .INIT(1)) u_gsh (
        .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv[1]), .prediction(pr[1]), .pred_strong(ps[1]),
        .branch(branch), .upd_pc(upd_pc), .taken(taken), .miss_count(mc[1])
    );
    bht_predictor #(.N(1), .IDX_W(4), .HIST_W(0), .INIT(0)) u_one (
        .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv[2]), .prediction(pr[2]), .pred_strong(ps[2]),
        .branch(branch), .upd_pc(upd_pc), .taken(taken), .miss_count(mc[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int e = 0; e < 16; e++) m_cnt[m][e] = 1;
            m_ghr[m] = 0;
            m_miss[m] = 0;
            m_pv[m] = 0;
            m_pr[m] = 0;
            m_ps[m] = 0;
        end
    endtask

    // Apply this cycle's update first, then read, so a same-index lookup sees the new value.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int pi, ui, pre, v;
            pi = int'(((pred_pc >> 2) ^ 32'(m_ghr[m])) & 32'hF);
            ui = int'(((upd_pc >> 2) ^ 32'(m_ghr[m])) & 32'hF);
            if (branch) begin
                pre = m_cnt[m][ui];
                if ((pre >= 2) != taken) m_miss[m] = m_miss[m] < 65535 ? m_miss[m] + 1 : 65535;
                m_cnt[m][ui] = taken ? (pre < 3 ? pre + 1 : 3) : (pre > 0 ? pre - 1 : 0);
                if (m == 1) m_ghr[m] = (m_ghr[m] * 2 + int'(taken)) % 4;
            end
            m_pv[m] = int'(pred_req);
            if (pred_req) begin
                v = m_cnt[m][pi];
                m_pr[m] = v >= 2 ? 1 : 0;
                m_ps[m] = (v == 0 || v == 3) ? 1 : 0;
            end
        end
    endtask

    task automatic check_models();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("valid%0d", m), 32'(pv[m]), 32'(m_pv[m]));
            chk($sformatf("pred%0d", m), 32'(pr[m]), 32'(m_pr[m]));
            chk($sformatf("strong%0d", m), 32'(ps[m]), 32'(m_ps[m]));
            chk($sformatf("miss%0d", m), 32'(mc[m]), 32'(m_miss[m]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_models();
    endtask

    // Reset lands mid-cycle with a lookup and an update pending; both must be dropped.
    task automatic do_reset();
        pred_req = 1'b1;
        branch = 1'b1;
        taken = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        check_models();
        chk("one_rst_valid", 32'(pv[2]), 32'd0);
        chk("one_rst_miss", 32'(mc[2]), 32'd0);
        @(posedge clk);
        #1;
        check_models();
        reset = 1'b1;
        pred_req = 1'b0;
        branch = 1'b0;
    endtask

    initial begin
        do_reset();
        branch = 1'b1; upd_pc = 32'h40; taken = 1'b1;
        repeat (4) cycle();
        branch = 1'b0; pred_req = 1'b1; pred_pc = 32'h40;
        cycle();
        chk("sat_hi_pred", 32'(pr[0]), 32'd1);
        chk("sat_hi_strong", 32'(ps[0]), 32'd1);
        pred_req = 1'b0; branch = 1'b1; taken = 1'b0;
        repeat (5) cycle();
        branch = 1'b0; pred_req = 1'b1;
        cycle();
        chk("sat_lo_pred", 32'(pr[0]), 32'd0);
        chk("sat_lo_strong", 32'(ps[0]), 32'd1);
        pred_req = 1'b0;
        cycle();
        chk("hold_valid", 32'(pv[0]), 32'd0);
        chk("hold_strong", 32'(ps[0]), 32'd1);

        do_reset();
        pred_req = 1'b1; pred_pc = 32'h40; branch = 1'b1; upd_pc = 32'h40; taken = 1'b1;
        cycle();
        chk("fwd_valid", 32'(pv[0]), 32'd1);
        chk("fwd_pred", 32'(pr[0]), 32'd1);
        chk("fwd_strong", 32'(ps[0]), 32'd0);
        pred_pc = 32'h48;
        cycle();
        chk("indep_pred", 32'(pr[0]), 32'd0);

        do_reset();
        branch = 1'b1; upd_pc = 32'h44; taken = 1'b1;
        cycle();
        chk("miss_1", 32'(mc[0]), 32'd1);
        cycle();
        chk("miss_2", 32'(mc[0]), 32'd1);
        taken = 1'b0;
        cycle();
        chk("miss_3", 32'(mc[0]), 32'd2);

        do_reset();
        branch = 1'b1; upd_pc = 32'h0; taken = 1'b1;
        repeat (2) cycle();
        branch = 1'b0; pred_req = 1'b1; pred_pc = 32'h0;
        cycle();
        chk("gsh_pred_e3", 32'(pr[1]), 32'd0);
        chk("gsh_strong_e3", 32'(ps[1]), 32'd0);
        chk("bim_pred_e0", 32'(pr[0]), 32'd1);
        pred_req = 1'b0; branch = 1'b1;
        cycle();
        branch = 1'b0; pred_req = 1'b1;
        cycle();
        chk("gsh_pred_e3_trained", 32'(pr[1]), 32'd1);

        do_reset();
        repeat (400) begin
            pred_req = 1'($urandom_range(0, 1));
            pred_pc = $urandom;
            branch = 1'($urandom_range(0, 1));
            upd_pc = $urandom;
            taken = 1'($urandom_range(0, 1));
            cycle();
        end

        pred_pc = 32'h40;
        do_reset();
        chk("rst_miss", 32'(mc[0]), 32'd0);
        cycle();
        chk("rst_release_valid", 32'(pv[0]), 32'd0);
        pred_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pred_pc = 32'(i * 4);
            cycle();
            chk("rst_pred", 32'(pr[0]), 32'd0);
        end

        do_reset();
        branch = 1'b1; upd_pc = 32'h0;
        for (int i = 0; i < 65537; i++) begin
            taken = (i % 2) == 0;
            @(posedge clk);
            #1;
            if (i == 0) chk("one_miss_first", 32'(mc[2]), 32'd1);
            if (i == 65534) chk("one_miss_max", 32'(mc[2]), 32'hFFFF);
        end
        chk("one_miss_hold", 32'(mc[2]), 32'hFFFF);
        branch = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
